// File: rtl/pcieifc_fifo_rd_stage_if.sv
// pcieifc_fifo_rd_stage_if: FIFO read port, flush control and beat stream of the read stage
interface pcieifc_fifo_rd_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 1
);
    localparam int OUT_WIDTH = DATA_WIDTH / RATIO;

    logic                  clr;
    logic                  fifo_rempty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_rinc;
    logic                  fifo_rclr;
    logic                  m_valid;
    logic [OUT_WIDTH-1:0]  m_data;
    logic                  m_last;
    logic                  m_ready;
    logic [1:0]            buf_cnt;

    // the read stage: pops the FIFO and masters the beat stream
    modport master (
        input  clr, fifo_rempty, fifo_rdata, m_ready,
        output fifo_rinc, fifo_rclr, m_valid, m_data, m_last, buf_cnt
    );

    // the surroundings: FIFO, flush source and downstream consumer
    modport slave (
        output clr, fifo_rempty, fifo_rdata, m_ready,
        input  fifo_rinc, fifo_rclr, m_valid, m_data, m_last, buf_cnt
    );
endinterface

// File: rtl/pcieifc_fifo_rd_stage.sv
// pcieifc_fifo_rd_stage: pops FWFT FIFO words into a 2-entry buffer and streams them as RATIO beats, LSB first
module pcieifc_fifo_rd_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    pcieifc_fifo_rd_stage_if.master io_bus
);
    localparam int OUT_WIDTH = DATA_WIDTH / RATIO;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic                  r_rdy_q;
    logic [1:0]            r_cnt;
    logic [IDX_W-1:0]      r_beat_idx;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_hs;
    logic                  w_retire;

    // pop decision uses only registered state and rempty, so m_ready never reaches rinc
    assign w_pop    = r_rdy_q & ~io_bus.fifo_rempty & (r_cnt != 2'd2) & ~io_bus.clr;
    assign w_last   = r_beat_idx == LAST_IDX;
    assign w_hs     = io_bus.m_valid & io_bus.m_ready;
    assign w_retire = w_hs & w_last;

    assign io_bus.fifo_rinc = w_pop;
    assign io_bus.fifo_rclr = io_bus.clr;
    assign io_bus.m_valid   = r_cnt != 2'd0;
    assign io_bus.m_data    = r_buf[r_rd_ptr][int'(r_beat_idx) * OUT_WIDTH +: OUT_WIDTH];
    assign io_bus.m_last    = io_bus.m_valid & w_last;
    assign io_bus.buf_cnt   = r_cnt;

    // hold off popping until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdy_q <= 1'b0;
        else        r_rdy_q <= 1'b1;
    end

    // capture the FIFO head word into the slot at the write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else if (w_pop) begin
            r_buf[r_wr_ptr] <= io_bus.fifo_rdata;
        end
    end

    // pointers, word count and beat index; a flush beats any pop or handshake in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_cnt      <= 2'd0;
            r_beat_idx <= '0;
        end else if (io_bus.clr) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_cnt      <= 2'd0;
            r_beat_idx <= '0;
        end else begin
            if (w_pop)    r_wr_ptr   <= ~r_wr_ptr;
            if (w_retire) r_rd_ptr   <= ~r_rd_ptr;
            if (w_hs)     r_beat_idx <= w_last ? '0 : r_beat_idx + 1'b1;
            r_cnt <= r_cnt + {1'b0, w_pop} - {1'b0, w_retire};
        end
    end
endmodule

// File: tb/tb_pcieifc_fifo_rd_stage.sv
// tb_pcieifc_fifo_rd_stage: three stages (RATIO 1, 2, 4) share one stimulus stream, each fed by its own FIFO model
module tb_pcieifc_fifo_rd_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic rdy = 1'b0;

    always #5 clk = ~clk;

    // every word ever written to the FIFO, in order; each instance reads it with its own head index
    logic [31:0] fmem [0:2047];
    int          tail = 0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mdat [3];
    logic        mval [3];
    logic        mlast [3];
    logic        rinc [3];
    logic [1:0]  cnt [3];
    int          hd [3];

    // reference: the next expected beat is beat ebeat of word ehead
    int          ehead [3];
    int          ebeat [3];
    logic        hold [3];
    logic [31:0] held [3];

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int R = 1 << k;
        int head = 0;
        pcieifc_fifo_rd_stage_if #(.DATA_WIDTH(32), .RATIO(R)) x ();
        pcieifc_fifo_rd_stage #(.DATA_WIDTH(32), .RATIO(R)) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .io_bus (x)
        );
        assign x.clr         = clr;
        assign x.m_ready     = rdy;
        assign x.fifo_rempty = head == tail;
        assign x.fifo_rdata  = fmem[head[10:0]];
        assign mdat[k]       = 32'(x.m_data);
        assign mval[k]       = x.m_valid;
        assign mlast[k]      = x.m_last;
        assign rinc[k]       = x.fifo_rinc;
        assign cnt[k]        = x.buf_cnt;
        assign hd[k]         = head;
        // FIFO model: rclr empties it, rinc advances the head
        always @(posedge clk) begin
            if (clr) head <= tail;
            else if (x.fifo_rinc) head <= head + 1;
        end
    end

    task automatic push(input logic [31:0] w);
        fmem[tail[10:0]] = w;
        tail++;
    endtask

    function automatic bit idle();
        for (int k = 0; k < 3; k++)
            if (mval[k] !== 1'b0 || hd[k] != tail) return 1'b0;
        return 1'b1;
    endfunction

    // one clock cycle; at the negedge every instance's stream is scored against the word list
    task automatic cyc();
        logic [31:0] w, ex, m;
        int ow;
        logic exl;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || clr) begin
                ehead[k] = clr ? tail : hd[k];
                ebeat[k] = 0;
                hold[k]  = 1'b0;
            end else begin
                if (hold[k]) begin
                    n_cmp++;
                    if (mval[k] !== 1'b1 || mdat[k] !== held[k]) begin
                        n_err++;
                        $display("FAIL hold_r%0d: valid=%b data=%h, required valid=1 data=%h", 1 << k, mval[k], mdat[k], held[k]);
                    end
                end
                if (mval[k] === 1'b1 && rdy) begin
                    ow  = 32 >> k;
                    m   = (ow == 32) ? 32'hFFFF_FFFF : (32'd1 << ow) - 32'd1;
                    w   = fmem[ehead[k][10:0]];
                    ex  = (w >> (ebeat[k] * ow)) & m;
                    exl = ebeat[k] == (1 << k) - 1;
                    n_cmp++;
                    if (ehead[k] >= hd[k] || mdat[k] !== ex || mlast[k] !== exl) begin
                        n_err++;
                        $display("FAIL beat_r%0d: data=%h last=%b, required data=%h last=%b (word %0d beat %0d, popped %0d)",
                                 1 << k, mdat[k], mlast[k], ex, exl, ehead[k], ebeat[k], hd[k]);
                    end
                    if (exl) begin
                        ehead[k]++;
                        ebeat[k] = 0;
                    end else begin
                        ebeat[k]++;
                    end
                end
                hold[k] = mval[k] === 1'b1 && !rdy;
                held[k] = mdat[k];
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget);
        int i = 0;
        rdy = 1'b1;
        while (!idle() && i < budget) begin
            cyc();
            i++;
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ehead[k] != tail || !idle()) begin
                n_err++;
                $display("FAIL drain_r%0d: delivered %0d words idle=%b, required %0d idle=1", 1 << k, ehead[k], idle(), tail);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy   = 1'b0;
        push(32'hC0DE_0001);
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (mval[k] !== 1'b0 || mdat[k] !== 32'd0 || mlast[k] !== 1'b0 || cnt[k] !== 2'd0 || rinc[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_r%0d: valid=%b data=%h last=%b cnt=%0d rinc=%b, required all 0", 1 << k, mval[k], mdat[k], mlast[k], cnt[k], rinc[k]);
            end
        end
        clr = 1'b1;
        #1;
        n_cmp++;
        if (g[0].x.fifo_rclr !== 1'b1 || rinc[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rclr: rclr=%b rinc=%b, required rclr=1 rinc=0", g[0].x.fifo_rclr, rinc[0]);
        end
        clr   = 1'b0;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rinc[k] !== 1'b0 || (k == 0 && g[0].x.fifo_rclr !== 1'b0)) begin
                n_err++;
                $display("FAIL release_rinc_r%0d: rinc=%b, required 0", 1 << k, rinc[k]);
            end
        end
        cyc();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rinc[k] !== 1'b1 || mval[k] !== 1'b0) begin
                n_err++;
                $display("FAIL first_pop_r%0d: rinc=%b valid=%b, required rinc=1 valid=0", 1 << k, rinc[k], mval[k]);
            end
        end
        cyc();
        n_cmp++;
        if (mval[0] !== 1'b1 || mdat[0] !== 32'hC0DE_0001 || mdat[1] !== 32'h0001 || mdat[2] !== 32'h01) begin
            n_err++;
            $display("FAIL first_word: valid=%b data=%h/%h/%h, required valid=1 data=c0de0001/00000001/00000001", mval[0], mdat[0], mdat[1], mdat[2]);
        end
        drain(50);
    endtask

    task automatic test_ratio1_stream();
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        #1;
        n_cmp++;
        if (rinc[0] !== 1'b1 || mval[0] !== 1'b0) begin
            n_err++;
            $display("FAIL stream_start: rinc=%b valid=%b, required rinc=1 valid=0", rinc[0], mval[0]);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++;
            if (mval[0] !== 1'b1 || mdat[0] !== 32'hA0 + 32'(i) || mlast[0] !== 1'b1 || cnt[0] !== 2'd1) begin
                n_err++;
                $display("FAIL stream_%0d: valid=%b data=%h last=%b cnt=%0d, required valid=1 data=%h last=1 cnt=1",
                         i, mval[0], mdat[0], mlast[0], cnt[0], 32'hA0 + 32'(i));
            end
        end
        drain(50);
    endtask

    task automatic test_ratio2_split();
        rdy = 1'b1;
        push(32'h1111_2222);
        cyc();
        n_cmp++;
        if (mval[1] !== 1'b1 || mdat[1] !== 32'h2222 || mlast[1] !== 1'b0) begin
            n_err++;
            $display("FAIL split_beat0: valid=%b data=%h last=%b, required valid=1 data=2222 last=0", mval[1], mdat[1], mlast[1]);
        end
        cyc();
        n_cmp++;
        if (mval[1] !== 1'b1 || mdat[1] !== 32'h1111 || mlast[1] !== 1'b1) begin
            n_err++;
            $display("FAIL split_beat1: valid=%b data=%h last=%b, required valid=1 data=1111 last=1", mval[1], mdat[1], mlast[1]);
        end
        cyc();
        n_cmp++;
        if (mval[1] !== 1'b0) begin
            n_err++;
            $display("FAIL split_done: valid=%b, required 0", mval[1]);
        end
        drain(50);
    endtask

    task automatic test_backpressure();
        int h0 [3];
        int first;
        rdy   = 1'b0;
        first = tail;
        for (int k = 0; k < 3; k++) h0[k] = hd[k];
        for (int i = 0; i < 5; i++) push($urandom);
        for (int i = 0; i < 6; i++) cyc();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (hd[k] - h0[k] != 2 || cnt[k] !== 2'd2 || rinc[k] !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_r%0d: pops=%0d cnt=%0d rinc=%b, required pops=2 cnt=2 rinc=0", 1 << k, hd[k] - h0[k], cnt[k], rinc[k]);
            end
        end
        n_cmp++;
        if (mdat[0] !== fmem[first[10:0]]) begin
            n_err++;
            $display("FAIL backpressure_head: data=%h, required %h", mdat[0], fmem[first[10:0]]);
        end
        drain(100);
    endtask

    task automatic test_clear();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) push($urandom);
        for (int i = 0; i < 4; i++) cyc();
        n_cmp++;
        if (cnt[0] !== 2'd2) begin
            n_err++;
            $display("FAIL clear_fill: cnt=%0d, required 2", cnt[0]);
        end
        rdy = 1'b1;
        clr = 1'b1;
        #1;
        n_cmp++;
        if (g[0].x.fifo_rclr !== 1'b1 || rinc[0] !== 1'b0) begin
            n_err++;
            $display("FAIL clear_cycle: rclr=%b rinc=%b, required rclr=1 rinc=0", g[0].x.fifo_rclr, rinc[0]);
        end
        cyc();
        clr = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (mval[k] !== 1'b0 || cnt[k] !== 2'd0) begin
                n_err++;
                $display("FAIL clear_after_r%0d: valid=%b cnt=%0d, required valid=0 cnt=0", 1 << k, mval[k], cnt[k]);
            end
        end
        drain(50);
    endtask

    task automatic test_reset_midword();
        logic [31:0] w0, w2;
        rdy = 1'b1;
        w0  = $urandom;
        push(w0);
        push($urandom);
        cyc();
        n_cmp++;
        if (mdat[1] !== {16'd0, w0[15:0]}) begin
            n_err++;
            $display("FAIL midword_beat0: data=%h, required %h", mdat[1], w0[15:0]);
        end
        cyc();
        n_cmp++;
        if (mdat[1] !== {16'd0, w0[31:16]} || mlast[1] !== 1'b1) begin
            n_err++;
            $display("FAIL midword_beat1: data=%h last=%b, required data=%h last=1", mdat[1], mlast[1], w0[31:16]);
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (mval[k] !== 1'b0 || cnt[k] !== 2'd0 || rinc[k] !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset_r%0d: valid=%b cnt=%0d rinc=%b, required all 0", 1 << k, mval[k], cnt[k], rinc[k]);
            end
        end
        cyc();
        w2 = $urandom;
        push(w2);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rinc[k] !== 1'b0) begin
                n_err++;
                $display("FAIL rearm_hold_r%0d: rinc=%b, required 0", 1 << k, rinc[k]);
            end
        end
        cyc();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rinc[k] !== 1'b1) begin
                n_err++;
                $display("FAIL rearm_pop_r%0d: rinc=%b, required 1", 1 << k, rinc[k]);
            end
        end
        cyc();
        n_cmp++;
        if (mval[1] !== 1'b1 || mdat[1] !== {16'd0, w2[15:0]}) begin
            n_err++;
            $display("FAIL rearm_word: valid=%b data=%h, required valid=1 data=%h", mval[1], mdat[1], w2[15:0]);
        end
        drain(50);
    endtask

    task automatic test_random();
        int pushed = 0;
        int cycles = 0;
        while ((pushed < 1000 || !idle()) && cycles < 30000) begin
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                push($urandom);
                pushed++;
            end
            rdy = $urandom_range(0, 1) == 1;
            cyc();
            cycles++;
        end
        n_cmp++;
        if (cycles >= 30000) begin
            n_err++;
            $display("FAIL random_budget: cycles=%0d, required < 30000", cycles);
        end
        drain(100);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            ehead[k] = 0;
            ebeat[k] = 0;
            hold[k]  = 1'b0;
            held[k]  = '0;
        end
        test_reset();
        test_ratio1_stream();
        test_ratio2_split();
        test_backpressure();
        test_clear();
        test_reset_midword();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
